// File: rtl/moveq_pkg.sv
// moveq_pkg: move word layout, register map and commit field positions for moveq_ctrl.
package moveq_pkg;
    localparam int MOVE_W = 65;
    localparam int DIR_BIT = 64;
    localparam int INT_HI = 63;
    localparam int INT_LO = 32;
    localparam int CNT_HI = 31;
    localparam int CNT_LO = 16;
    localparam int ADD_HI = 15;
    localparam int ADD_LO = 0;
    localparam logic [3:0] ADR_INTERVAL = 4'd0;
    localparam logic [3:0] ADR_CNTADD = 4'd1;
    localparam logic [3:0] ADR_COMMIT = 4'd2;
    localparam logic [3:0] ADR_STATUS = 4'd3;
    localparam logic [3:0] ADR_FLUSH = 4'd4;
    localparam int CH_HI = 11;
    localparam int CH_LO = 8;
    localparam int CDIR_BIT = 0;
endpackage

// File: rtl/moveq_fifo.sv
// moveq_fifo: single-channel DEPTH x 65 move FIFO; flush beats push and pull, full is pre-edge.
module moveq_fifo
    import moveq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pull,
    input  logic              flush,
    input  logic [MOVE_W-1:0] din,
    output logic [MOVE_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);
    logic [MOVE_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pull && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/moveq_ctrl.sv
// moveq_ctrl: Wishbone-staged move commits into per-channel FIFOs feeding step schedulers.
// Optional MOVEQ_FLUSH_EN adds a per-channel flush register at address 4.
module moveq_ctrl
    import moveq_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_we_i,
    input  logic [3:0]               wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic [MOVE_W*NUM_CH-1:0] mq_data,
    output logic [NUM_CH-1:0]        mq_avail,
    input  logic [NUM_CH-1:0]        mq_pull
);
    logic [31:0] stage_interval, stage_cnt_add, status;
    logic [NUM_CH-1:0] ovf, push, flush, empty, full;
    logic [MOVE_W-1:0] mv;
    logic wr;
    logic [3:0] cch;
    assign wr = wb_cyc_i & wb_stb_i & wb_we_i;
    assign wb_ack_o = wb_cyc_i & wb_stb_i;
    assign cch = wb_dat_i[CH_HI:CH_LO];
    assign mq_avail = ~empty;
    always_comb begin
        mv = '0;
        mv[DIR_BIT] = wb_dat_i[CDIR_BIT];
        mv[INT_HI:INT_LO] = stage_interval;
        mv[CNT_HI:CNT_LO] = stage_cnt_add[31:16];
        mv[ADD_HI:ADD_LO] = stage_cnt_add[15:0];
    end
`ifdef MOVEQ_FLUSH_EN
    assign flush = (wr && wb_adr_i == ADR_FLUSH) ? wb_dat_i[NUM_CH-1:0] : '0;
`else
    assign flush = '0;
`endif
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Out-of-range channel indices match no k, so such commits vanish here.
        assign push[k] = wr && wb_adr_i == ADR_COMMIT && cch == 4'(k);
        moveq_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (push[k]),
            .pull (mq_pull[k]),
            .flush(flush[k]),
            .din  (mv),
            .head (mq_data[MOVE_W*k +: MOVE_W]),
            .empty(empty[k]),
            .full (full[k])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_interval <= '0;
            stage_cnt_add <= '0;
            ovf <= '0;
        end else begin
            if (wr && wb_adr_i == ADR_INTERVAL) stage_interval <= wb_dat_i;
            if (wr && wb_adr_i == ADR_CNTADD) stage_cnt_add <= wb_dat_i;
            ovf <= (ovf & ~((wr && wb_adr_i == ADR_STATUS) ? wb_dat_i[NUM_CH-1:0] : '0))
                 | (push & full & ~flush);
        end
    end
    assign status = {8'b0, 8'(empty), 8'(full), 8'(ovf)};
    assign wb_dat_o = wb_adr_i == ADR_INTERVAL ? stage_interval
                    : wb_adr_i == ADR_CNTADD ? stage_cnt_add
                    : wb_adr_i == ADR_STATUS ? status : '0;
endmodule

// File: tb/tb_moveq_ctrl.sv
// tb_moveq_ctrl: directed plus randomized stimulus checked against per-channel queue model.
module tb_moveq_ctrl;
    localparam int NUM_CH = 2;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 1;
    logic wb_stb_i = 0, wb_cyc_i = 0, wb_we_i = 0;
    logic [3:0] wb_adr_i = 0;
    logic [31:0] wb_dat_i = 0, wb_dat_o;
    logic wb_ack_o;
    logic [65*NUM_CH-1:0] mq_data;
    logic [NUM_CH-1:0] mq_avail, mq_pull = 0;
    int n_chk = 0, n_err = 0;
    logic [64:0] q [NUM_CH][$];
    logic [31:0] m_int = 0, m_ca = 0;
    logic [NUM_CH-1:0] m_ovf = 0;

    moveq_ctrl #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .mq_data(mq_data), .mq_avail(mq_avail), .mq_pull(mq_pull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        logic [31:0] s = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            s[16+k] = q[k].size() == 0;
            s[8+k] = q[k].size() == DEPTH;
            s[k] = m_ovf[k];
        end
        return a == 0 ? m_int : a == 1 ? m_ca : a == 3 ? s : 32'h0;
    endfunction

    task automatic step(input logic r, input logic c, input logic s, input logic w,
                        input logic [3:0] a, input logic [31:0] d, input logic [NUM_CH-1:0] p);
        logic wr;
        logic [NUM_CH-1:0] fl, fullp, pl;
        int ch;
        @(negedge clk);
        rst = r; wb_cyc_i = c; wb_stb_i = s; wb_we_i = w; wb_adr_i = a; wb_dat_i = d; mq_pull = p;
        #1;
        chk("ack", 65'(wb_ack_o), 65'(c & s));
        chk("rdata", 65'(wb_dat_o), 65'(exp_read(a)));
        for (int k = 0; k < NUM_CH; k++) begin
            chk($sformatf("avail%0d", k), 65'(mq_avail[k]), 65'(q[k].size() != 0));
            chk($sformatf("data%0d", k), mq_data[65*k +: 65], q[k].size() != 0 ? q[k][0] : 65'h0);
        end
        if (r) begin
            for (int k = 0; k < NUM_CH; k++) q[k].delete();
            m_int = 0; m_ca = 0; m_ovf = 0;
            return;
        end
        wr = c & s & w;
        fl = 0;
`ifdef MOVEQ_FLUSH_EN
        if (wr && a == 4) fl = d[NUM_CH-1:0];
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            fullp[k] = q[k].size() == DEPTH;
            pl[k] = p[k] && q[k].size() != 0;
        end
        for (int k = 0; k < NUM_CH; k++)
            if (fl[k]) q[k].delete();
            else if (pl[k]) void'(q[k].pop_front());
        if (wr && a == 2) begin
            ch = int'(d[11:8]);
            if (ch < NUM_CH && !fl[ch]) begin
                if (fullp[ch]) m_ovf[ch] = 1'b1;
                else q[ch].push_back({d[0], m_int, m_ca});
            end
        end
        if (wr && a == 3) m_ovf = m_ovf & ~d[NUM_CH-1:0];
        if (wr && a == 0) m_int = d;
        if (wr && a == 1) m_ca = d;
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d, input logic [NUM_CH-1:0] p);
        step(0, 1, 1, 1, a, d, p);
    endtask

    task automatic idle(input logic [3:0] a, input logic [NUM_CH-1:0] p);
        step(0, 0, 0, 0, a, 0, p);
    endtask

    initial begin
        int pp;
        logic [3:0] a;
        logic [31:0] d;
        logic [NUM_CH-1:0] p;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        idle(3, 0);
        // basic move to ch1, then pull it
        wb(0, 32'h0000_1000, 0);
        wb(1, 32'h0005_FFFE, 0);
        wb(2, 32'h0000_0101, 0);
        idle(0, 2'b10);
        idle(0, 0);
        // fill ch0 past depth, drain in order, clear overflow
        for (int i = 0; i < 5; i++) begin
            wb(0, 32'h100 + i, 0);
            wb(2, 32'h0000_0000 | i % 2, 0);
        end
        idle(3, 0);
        for (int i = 0; i < 4; i++) idle(3, 2'b01);
        wb(3, 32'h1, 0);
        idle(3, 0);
        // concurrency: push+pull with 2 entries, then with full queue
        wb(2, 0, 0); wb(2, 1, 0);
        wb(2, 0, 2'b01);
        wb(2, 0, 0); wb(2, 0, 0);
        wb(2, 1, 2'b01);
        idle(3, 0);
        // invalid channel
        wb(2, 32'h0000_0501, 0);
        idle(3, 0);
        // reset mid-operation with a pending pull
        step(1, 1, 1, 1, 2, 0, 2'b01);
        idle(3, 0);
        wb(2, 32'h0000_0101, 0);
        idle(3, 0);
        // flush ch0 only
        wb(2, 0, 0); wb(2, 1, 0);
        wb(4, 32'h1, 0);
        idle(3, 0);
        // randomized phases with varying pull pressure
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pp = $urandom_range(0, 8);
            a = 4'($urandom_range(0, 9));
            if (a > 4) a = 2;
            d = $urandom;
            if (a == 2) d[11:8] = 4'($urandom_range(0, 9) < 8 ? $urandom_range(0, 1) : $urandom_range(2, 15));
            for (int k = 0; k < NUM_CH; k++) p[k] = $urandom_range(0, 9) < pp;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 5) != 0, a, d, p);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
